// File: rtl/box_map_if.sv
// Pixel, bomberman-position and blast-request bus between the game logic and box_map.
// The master drives the pixel, position and blast request; the slave returns render flags, blocking and blast status.
interface box_map_if;
  logic [9:0] v_x;
  logic [9:0] v_y;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic       blast_valid;
  logic [3:0] blast_col;
  logic [3:0] blast_row;
  logic [2:0] blast_range;
  logic       blast_ready;
  logic       blast_done;
  logic [2:0] boxes_cleared;
  logic       box_on;
  logic       pillar_on;
  logic [3:0] tile_px;
  logic [3:0] tile_py;
  logic [3:0] bomberman_blocked;

  modport master (
    output v_x, v_y, b_x, b_y, blast_valid, blast_col, blast_row, blast_range,
    input  blast_ready, blast_done, boxes_cleared, box_on, pillar_on,
           tile_px, tile_py, bomberman_blocked
  );

  modport slave (
    input  v_x, v_y, b_x, b_y, blast_valid, blast_col, blast_row, blast_range,
    output blast_ready, blast_done, boxes_cleared, box_on, pillar_on,
           tile_px, tile_py, bomberman_blocked
  );
endinterface

// File: rtl/box_map.sv
// Live arena tile map: box bitmap plus odd/odd pillars, pixel hit pipeline,
// bomberman blocking probes and a walking FSM that clears boxes hit by a blast.
module box_map #(
  parameter int unsigned ARENA_X0 = 143,
  parameter int unsigned ARENA_Y0 = 49,
  parameter int unsigned COLS     = 15,
  parameter int unsigned ROWS     = 11,
  parameter logic [COLS*ROWS-1:0] INIT_MAP = (COLS*ROWS)'(18'h2_0002)
) (
  input logic      clk,
  input logic      reset,
  box_map_if.slave bus
);
  localparam int unsigned NTILES = COLS * ROWS;
  localparam int unsigned IDXW   = $clog2(NTILES);
  localparam int unsigned CW     = 12;
  localparam int unsigned TW     = 6;
  localparam logic signed [CW-1:0] X0  = CW'(ARENA_X0);
  localparam logic signed [CW-1:0] Y0  = CW'(ARENA_Y0);
  localparam logic signed [CW-1:0] AW  = CW'(16 * COLS);
  localparam logic signed [CW-1:0] AH  = CW'(16 * ROWS);
  localparam logic signed [CW-1:0] O1  = CW'(1);
  localparam logic signed [CW-1:0] O15 = CW'(15);
  localparam logic signed [CW-1:0] O16 = CW'(16);
  localparam logic signed [TW-1:0] COLS_T = TW'(COLS);
  localparam logic signed [TW-1:0] ROWS_T = TW'(ROWS);
  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  function automatic logic box_at(input logic [3:0] c, input logic [3:0] r,
                                  input logic [NTILES-1:0] m);
    int unsigned i;
    i = 32'(r) * COLS + 32'(c);
    return (i < NTILES) ? m[IDXW'(i)] : 1'b0;
  endfunction

  // A probe is solid when off-arena, on a pillar, or on a present box.
  function automatic logic probe_hit(input logic signed [CW-1:0] dx,
                                     input logic signed [CW-1:0] dy,
                                     input logic [NTILES-1:0] m);
    logic hit;
    if (dx[CW-1] || dy[CW-1] || (dx >= AW) || (dy >= AH)) hit = 1'b1;
    else hit = (dx[4] & dy[4]) | box_at(dx[7:4], dy[7:4], m);
    return hit;
  endfunction

  logic [NTILES-1:0] map_q;
  state_t            state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [2:0]        k_q, k_d, cnt_q, cnt_d, rng_q, rng_d;
  logic [3:0]        cc_q, cc_d, cr_q, cr_d;
  logic              clr;
  logic              ready_q, done_q;
  logic [2:0]        cleared_q;

  logic signed [CW-1:0] pdx, pdy, bdx, bdy;
  logic                 s1_in;
  logic [3:0]           s1_col, s1_row, s1_px, s1_py;
  logic                 box_q, pil_q;
  logic [3:0]           tpx_q, tpy_q, blk_q, blk_d;

  logic signed [TW-1:0] tc, tr, ks;
  logic                 t_out, t_box, t_pillar;
  logic [IDXW-1:0]      t_idx;

  assign pdx = signed'(CW'(bus.v_x)) - X0;
  assign pdy = signed'(CW'(bus.v_y)) - Y0;
  assign bdx = signed'(CW'(bus.b_x)) - X0;
  assign bdy = signed'(CW'(bus.b_y)) - Y0;

  // Two-stage pixel pipeline: tile decode, then map/pillar lookup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_in  <= 1'b0;
      s1_col <= '0;
      s1_row <= '0;
      s1_px  <= '0;
      s1_py  <= '0;
      box_q  <= 1'b0;
      pil_q  <= 1'b0;
      tpx_q  <= '0;
      tpy_q  <= '0;
      blk_q  <= '0;
    end else begin
      s1_in  <= !pdx[CW-1] && !pdy[CW-1] && (pdx < AW) && (pdy < AH);
      s1_col <= pdx[7:4];
      s1_row <= pdy[7:4];
      s1_px  <= pdx[3:0];
      s1_py  <= pdy[3:0];
      box_q  <= s1_in & box_at(s1_col, s1_row, map_q);
      pil_q  <= s1_in & s1_col[0] & s1_row[0];
      tpx_q  <= s1_px;
      tpy_q  <= s1_py;
      blk_q  <= blk_d;
    end
  end

  always_comb begin
    blk_d    = '0;
    blk_d[3] = probe_hit(bdx, bdy - O1, map_q)  | probe_hit(bdx + O15, bdy - O1, map_q);
    blk_d[2] = probe_hit(bdx, bdy + O16, map_q) | probe_hit(bdx + O15, bdy + O16, map_q);
    blk_d[1] = probe_hit(bdx - O1, bdy, map_q)  | probe_hit(bdx - O1, bdy + O15, map_q);
    blk_d[0] = probe_hit(bdx + O16, bdy, map_q) | probe_hit(bdx + O16, bdy + O15, map_q);
  end

  // Current walk target: centre offset by k tiles along dir.
  always_comb begin
    ks = signed'(TW'(k_q));
    tc = signed'(TW'(cc_q));
    tr = signed'(TW'(cr_q));
    case (dir_q)
      D_UP:    tr = tr - ks;
      D_DOWN:  tr = tr + ks;
      D_LEFT:  tc = tc - ks;
      default: tc = tc + ks;
    endcase
    t_out    = tc[TW-1] | tr[TW-1] | (tc >= COLS_T) | (tr >= ROWS_T);
    t_pillar = tc[0] & tr[0];
    t_box    = !t_out && box_at(tc[3:0], tr[3:0], map_q);
    t_idx    = IDXW'(32'(tr[3:0]) * COLS + 32'(tc[3:0]));
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    cc_d    = cc_q;
    cr_d    = cr_q;
    rng_d   = rng_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (bus.blast_valid) begin
        cc_d    = bus.blast_col;
        cr_d    = bus.blast_row;
        rng_d   = bus.blast_range;
        dir_d   = D_UP;
        k_d     = 3'd1;
        cnt_d   = '0;
        state_d = (bus.blast_range == 3'd0) ? DONE : WALK;
      end
      WALK: begin
        if (t_out || t_pillar || t_box || (k_q == rng_q)) begin
          if (t_box && !t_pillar) begin
            clr   = 1'b1;
            cnt_d = 3'(cnt_q + 3'd1);
          end
          k_d = 3'd1;
          if (dir_q == D_RIGHT) state_d = DONE;
          else dir_d = 2'(dir_q + 2'd1);
        end else begin
          k_d = 3'(k_q + 3'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      map_q     <= INIT_MAP;
      state_q   <= IDLE;
      dir_q     <= D_UP;
      k_q       <= 3'd1;
      cnt_q     <= '0;
      cc_q      <= '0;
      cr_q      <= '0;
      rng_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      cleared_q <= '0;
    end else begin
      if (clr) map_q[t_idx] <= 1'b0;
      state_q <= state_d;
      dir_q   <= dir_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      cc_q    <= cc_d;
      cr_q    <= cr_d;
      rng_q   <= rng_d;
      ready_q <= (state_d == IDLE);
      done_q  <= (state_d == DONE);
      if (state_d == DONE) cleared_q <= cnt_d;
    end
  end

  assign bus.blast_ready       = ready_q;
  assign bus.blast_done        = done_q;
  assign bus.boxes_cleared     = cleared_q;
  assign bus.box_on            = box_q;
  assign bus.pillar_on         = pil_q;
  assign bus.tile_px           = tpx_q;
  assign bus.tile_py           = tpy_q;
  assign bus.bomberman_blocked = blk_q;
endmodule

// File: tb/tb_box_map.sv
// Directed bench for box_map: pixel and blocking vector tables plus blast sequences.
module tb_box_map;
  logic clk = 1'b0;
  logic reset;

  box_map_if bus();

  box_map dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       box;
    logic       pil;
    logic [3:0] tpx;
    logic [3:0] tpy;
  } pix_vec_t;

  typedef struct {
    logic [9:0] bx;
    logic [9:0] by;
    logic [3:0] blk;
  } blk_vec_t;

  pix_vec_t pv[9];
  blk_vec_t bv[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    bus.v_x = x;
    bus.v_y = y;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_blast(input string name, input logic [3:0] c, input logic [3:0] r,
                           input logic [2:0] rng, input int exp_n,
                           input logic [2:0] exp_cnt, input bit hold);
    int   n;
    logic busy_ready;
    check({name, "_ready_idle"}, 32'(bus.blast_ready), 32'd1);
    bus.blast_col   = c;
    bus.blast_row   = r;
    bus.blast_range = rng;
    bus.blast_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.blast_valid = 1'b0;
    n          = 1;
    busy_ready = bus.blast_ready;
    while (!bus.blast_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      busy_ready |= bus.blast_ready;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_n));
    check({name, "_ready_busy"}, 32'(busy_ready), 32'd0);
    check({name, "_cleared"}, 32'(bus.boxes_cleared), 32'(exp_cnt));
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, 32'(bus.blast_done), 32'd0);
    check({name, "_ready_after"}, 32'(bus.blast_ready), 32'd1);
    check({name, "_cleared_held"}, 32'(bus.boxes_cleared), 32'(exp_cnt));
    if (hold) begin
      bus.blast_valid = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_no_reaccept"}, 32'(bus.blast_ready), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen_done;

    pv[0] = '{10'd159, 10'd49,  1'b1, 1'b0, 4'h0, 4'h0};
    pv[1] = '{10'd176, 10'd66,  1'b1, 1'b0, 4'h1, 4'h1};
    pv[2] = '{10'd174, 10'd65,  1'b0, 1'b1, 4'hF, 4'h0};
    pv[3] = '{10'd142, 10'd49,  1'b0, 1'b0, 4'hF, 4'h0};
    pv[4] = '{10'd383, 10'd49,  1'b0, 1'b0, 4'h0, 4'h0};
    pv[5] = '{10'd382, 10'd224, 1'b0, 1'b0, 4'hF, 4'hF};
    pv[6] = '{10'd382, 10'd225, 1'b0, 1'b0, 4'hF, 4'h0};
    pv[7] = '{10'd191, 10'd97,  1'b0, 1'b1, 4'h0, 4'h0};
    pv[8] = '{10'd160, 10'd82,  1'b0, 1'b0, 4'h1, 4'h1};

    bv[0] = '{10'd143, 10'd65,  4'b0011};
    bv[1] = '{10'd143, 10'd49,  4'b1011};
    bv[2] = '{10'd367, 10'd209, 4'b0101};

    reset           = 1'b0;
    bus.v_x         = '0;
    bus.v_y         = '0;
    bus.b_x         = '0;
    bus.b_y         = '0;
    bus.blast_valid = 1'b0;
    bus.blast_col   = '0;
    bus.blast_row   = '0;
    bus.blast_range = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   32'(bus.blast_ready), 32'd1);
    check("rst_done",    32'(bus.blast_done), 32'd0);
    check("rst_cleared", 32'(bus.boxes_cleared), 32'd0);
    check("rst_box",     32'(bus.box_on), 32'd0);
    check("rst_pillar",  32'(bus.pillar_on), 32'd0);
    check("rst_tpx",     32'(bus.tile_px), 32'd0);
    check("rst_tpy",     32'(bus.tile_py), 32'd0);
    check("rst_blocked", 32'(bus.bomberman_blocked), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      pix(pv[i].x, pv[i].y);
      check($sformatf("pix%0d_box", i), 32'(bus.box_on), 32'(pv[i].box));
      check($sformatf("pix%0d_pillar", i), 32'(bus.pillar_on), 32'(pv[i].pil));
      check($sformatf("pix%0d_tpx", i), 32'(bus.tile_px), 32'(pv[i].tpx));
      check($sformatf("pix%0d_tpy", i), 32'(bus.tile_py), 32'(pv[i].tpy));
    end

    for (int i = 0; i < 3; i++) begin
      bus.b_x = bv[i].bx;
      bus.b_y = bv[i].by;
      @(posedge clk);
      #1;
      check($sformatf("blk%0d", i), 32'(bus.bomberman_blocked), 32'(bv[i].blk));
    end

    run_blast("b1", 4'd0, 4'd0, 3'd2, 6, 3'd1, 1'b0);
    pix(10'd159, 10'd49);
    check("b1_box10_gone", 32'(bus.box_on), 32'd0);
    pix(10'd176, 10'd66);
    check("b1_box21_kept", 32'(bus.box_on), 32'd1);

    bus.b_x = 10'd143;
    bus.b_y = 10'd49;
    @(posedge clk);
    #1;
    check("blk_after_clear", 32'(bus.bomberman_blocked), 32'(4'b1010));

    run_blast("b2", 4'd2, 4'd3, 3'd3, 8, 3'd1, 1'b1);
    pix(10'd175, 10'd65);
    check("b2_box21_gone", 32'(bus.box_on), 32'd0);
    check("b2_no_pillar", 32'(bus.pillar_on), 32'd0);

    run_blast("b3", 4'd15, 4'd15, 3'd3, 5, 3'd0, 1'b0);
    run_blast("b4", 4'd2, 4'd2, 3'd0, 1, 3'd0, 1'b0);

    // Reset in the middle of a long blast.
    bus.blast_col   = 4'd7;
    bus.blast_row   = 4'd5;
    bus.blast_range = 3'd7;
    bus.blast_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.blast_valid = 1'b0;
    check("rb_busy", 32'(bus.blast_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rb_ready_in_reset", 32'(bus.blast_ready), 32'd1);
    check("rb_done_in_reset",  32'(bus.blast_done), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen_done |= bus.blast_done;
    end
    check("rb_no_done", 32'(seen_done), 32'd0);
    check("rb_ready",   32'(bus.blast_ready), 32'd1);
    check("rb_cleared", 32'(bus.boxes_cleared), 32'd0);
    pix(10'd159, 10'd49);
    check("rb_box10_back", 32'(bus.box_on), 32'd1);
    pix(10'd176, 10'd66);
    check("rb_box21_back", 32'(bus.box_on), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
